// File: rtl/id_ex_pipe_pkg.sv
// rtl/id_ex_pipe_pkg.sv - shared RV32I opcode, ALU and branch constants
// Purpose: opcode encodings (LOAD, NOP and the other RV32I major opcodes),
//          alu_op / branch_alu_op encodings shared with ex_ctrl, and the
//          register-hit helper used by the forwarding muxes.
// Ports:   none (package).
package id_ex_pipe_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // ADDI x0,x0,0
  localparam logic [6:0] OPC_NOP      = OPC_OP_IMM;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ   = 3'd0,
    BR_NE   = 3'd1,
    BR_LT   = 3'd2,
    BR_GE   = 3'd3,
    BR_LTU  = 3'd4,
    BR_GEU  = 3'd5,
    BR_NONE = 3'd6
  } branch_alu_op_e;

  // A later stage supplies rs only when it really writes a non-x0 rd == rs.
  function automatic logic rd_hit(input logic we, input logic [4:0] rd,
                                  input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_pipe_fwd_mux.sv
// rtl/id_ex_pipe_fwd_mux.sv - combinational MEM/WB forwarding mux for one operand
// Purpose: selects MEM result, WB result or the stored operand for one rs.
//          MEM wins over WB; x0 is never forwarded.
// Ports:   i_rs/i_stored      - stored source register and its captured value
//          i_mem_we/rd/data   - MEM stage write-back intent and result
//          i_wb_we/rd/data    - WB stage write port
//          o_data             - forwarded operand
module fwd_mux
  import id_ex_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      i_rs,
  input  logic [XLEN-1:0] i_stored,
  input  logic            i_mem_we,
  input  logic [4:0]      i_mem_rd,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_stored;
    if (rd_hit(i_mem_we, i_mem_rd, i_rs)) begin
      o_data = i_mem_data;
    end else if (rd_hit(i_wb_we, i_wb_rd, i_rs)) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - RV32I ID/EX pipeline register with forwarding and load-use bubble
// Purpose: registers decoded ID fields for ex_ctrl, forwards MEM/WB results
//          onto data1/data2, inserts one bubble on a load-use hazard, honours
//          downstream stall and branch/jump flush (stall_in > flush > load-use).
// Ports:   clk, rst_n (async active-low)
//          id_*        - decoded instruction, operands, pc, imm from ID
//          stall_in    - MEM hold request; flush - taken branch/jump from EX
//          mem_*/wb_*  - later-stage write-back info for forwarding
//          ex_*        - registered fields and forwarded operands to ex_ctrl
//          id_stall    - freeze IF/ID this cycle
//          stall_cnt   - load-use bubble count (only with ID_EX_PERF_EN)
// Config:  `define ID_EX_PERF_EN to add the stall_cnt performance counter.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter logic [6:0] NOP_OPCODE = 7'b0010011,
  parameter int         XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic [6:0]      id_funct7,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_data1,
  input  logic [XLEN-1:0] id_data2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            stall_in,
  input  logic            flush,
  input  logic            mem_reg_we,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_reg_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_data1,
  output logic [XLEN-1:0] ex_data2,
`ifdef ID_EX_PERF_EN
  output logic [31:0]     stall_cnt,
`endif
  output logic            id_stall
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [XLEN-1:0] r_data1;
  logic [XLEN-1:0] r_data2;

  logic            w_load_use;
  logic            w_bubble;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;

  // Conservative: both rs fields are compared whatever the ID opcode uses.
  assign w_load_use = r_valid && (r_opcode == OPC_LOAD) && (r_rd != 5'd0) &&
                      id_valid && ((id_rs1 == r_rd) || (id_rs2 == r_rd));

  assign w_bubble = !stall_in && (flush || w_load_use);
  assign id_stall = stall_in || (!flush && w_load_use);

  fwd_mux #(.XLEN(XLEN)) u_fwd1 (
    .i_rs       (r_rs1),
    .i_stored   (r_data1),
    .i_mem_we   (mem_reg_we),
    .i_mem_rd   (mem_rd),
    .i_mem_data (mem_fwd_data),
    .i_wb_we    (wb_reg_we),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .o_data     (w_fwd1)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd2 (
    .i_rs       (r_rs2),
    .i_stored   (r_data2),
    .i_mem_we   (mem_reg_we),
    .i_mem_rd   (mem_rd),
    .i_mem_data (mem_fwd_data),
    .i_wb_we    (wb_reg_we),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .o_data     (w_fwd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_opcode <= NOP_OPCODE;
      r_funct3 <= '0;
      r_funct7 <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_data1  <= '0;
      r_data2  <= '0;
    end else if (stall_in) begin
      // Fields hold, but operands absorb whatever is being forwarded now so a
      // producer leaving WB during the hold is not lost.
      r_data1 <= w_fwd1;
      r_data2 <= w_fwd2;
    end else if (w_bubble) begin
      // rs=x0 with zero data keeps the bubble's operands zero under forwarding.
      r_valid  <= 1'b0;
      r_opcode <= NOP_OPCODE;
      r_funct3 <= '0;
      r_funct7 <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_data1  <= '0;
      r_data2  <= '0;
    end else begin
      r_valid  <= id_valid;
      r_pc     <= id_pc;
      r_opcode <= id_opcode;
      r_funct3 <= id_funct3;
      r_funct7 <= id_funct7;
      r_rd     <= id_rd;
      r_imm    <= id_imm;
      r_rs1    <= id_rs1;
      r_rs2    <= id_rs2;
      r_data1  <= id_data1;
      r_data2  <= id_data2;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!stall_in && !flush && w_load_use) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign ex_valid  = r_valid;
  assign ex_pc     = r_pc;
  assign ex_opcode = r_opcode;
  assign ex_funct3 = r_funct3;
  assign ex_funct7 = r_funct7;
  assign ex_rd     = r_rd;
  assign ex_imm    = r_imm;
  assign ex_data1  = w_fwd1;
  assign ex_data2  = w_fwd2;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - self-checking bench for id_ex_pipe
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  localparam logic [6:0] N = 7'b0010011;
  localparam logic [6:0] A = 7'b0110011;
  localparam logic [6:0] L = 7'b0000011;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_data1, id_data2, id_imm;
  logic        stall_in, flush;
  logic        mem_reg_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_reg_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_rd;
  logic [31:0] ex_imm, ex_data1, ex_data2;
  logic        id_stall;
`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt;
`endif

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
    .stall_in(stall_in), .flush(flush),
    .mem_reg_we(mem_reg_we), .mem_rd(mem_rd), .mem_fwd_data(mem_fwd_data),
    .wb_reg_we(wb_reg_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_data1(ex_data1), .ex_data2(ex_data2),
`ifdef ID_EX_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .id_stall(id_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2;
    logic        stall, fl;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        e_stall, e_valid;
    logic [6:0]  e_opc;
    logic [4:0]  e_rd;
    logic [31:0] e_d1, e_d2, e_cnt;
  } vec_t;

  vec_t tbl[20];

  // Behavioural model of the EX slot contents.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [6:0]  m_opc;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [31:0] m_imm, m_d1, m_d2;
  logic [31:0] m_cnt;

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] stored);
    if (rs == 0) return stored;
    if (mem_reg_we && mem_rd == rs) return mem_fwd_data;
    if (wb_reg_we && wb_rd == rs) return wb_data;
    return stored;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_opc = N; m_f3 = 0; m_f7 = 0; m_rd = 0;
    m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_d1 = 0; m_d2 = 0; m_cnt = 0;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_opcode = N; id_funct3 = 0; id_funct7 = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_data1 = 0; id_data2 = 0; id_imm = 0;
    stall_in = 0; flush = 0; mem_reg_we = 0; mem_rd = 0; mem_fwd_data = 0;
    wb_reg_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  logic [6:0] opc_pool [4];

  initial begin
    opc_pool[0] = OPC_LOAD; opc_pool[1] = OPC_OP;
    opc_pool[2] = OPC_OP_IMM; opc_pool[3] = OPC_STORE;

    //            v opc rs1 rs2 rd d1 d2        st fl mwe mrd mdata            wwe wrd wdata          e_st e_v e_opc e_rd e_d1 e_d2 e_cnt
    tbl[0]  = '{0, N, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,                 0, 0, 0,               0, 0, N, 0, 0, 0, 0};
    tbl[1]  = '{1, A, 5, 0, 6, 0, 0,            0, 0, 0, 0, 0,                 0, 0, 0,               0, 0, N, 0, 0, 0, 0};
    tbl[2]  = '{0, N, 0, 0, 0, 0, 0,            1, 0, 1, 5, 32'h10,            0, 0, 0,               1, 1, A, 6, 32'h10, 0, 0};
    tbl[3]  = '{0, N, 0, 0, 0, 0, 0,            1, 0, 1, 5, 32'h10,            1, 5, 32'h20,          1, 1, A, 6, 32'h10, 0, 0};
    tbl[4]  = '{0, N, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0,                 0, 0, 0,               1, 1, A, 6, 32'h10, 0, 0};
    tbl[5]  = '{1, L, 0, 0, 7, 0, 0,            0, 0, 0, 0, 0,                 0, 0, 0,               0, 1, A, 6, 32'h10, 0, 0};
    tbl[6]  = '{1, A, 1, 7, 8, 32'h11, 32'h22,  0, 0, 0, 0, 0,                 0, 0, 0,               1, 1, L, 7, 0, 0, 0};
    tbl[7]  = '{1, A, 1, 7, 8, 32'h11, 32'h22,  0, 0, 1, 7, 0,                 0, 0, 0,               0, 0, N, 0, 0, 0, 1};
    tbl[8]  = '{0, N, 0, 0, 0, 0, 0,            1, 0, 1, 7, 32'hDEADBEEF,      0, 0, 0,               1, 1, A, 8, 32'h11, 32'hDEADBEEF, 1};
    tbl[9]  = '{0, N, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0,                 1, 7, 32'hCAFEF00D,    1, 1, A, 8, 32'h11, 32'hCAFEF00D, 1};
    tbl[10] = '{0, N, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0,                 0, 0, 0,               1, 1, A, 8, 32'h11, 32'hCAFEF00D, 1};
    tbl[11] = '{1, L, 0, 0, 9, 0, 0,            0, 0, 0, 0, 0,                 0, 0, 0,               0, 1, A, 8, 32'h11, 32'hCAFEF00D, 1};
    tbl[12] = '{1, A, 9, 0, 2, 0, 0,            0, 1, 0, 0, 0,                 0, 0, 0,               0, 1, L, 9, 0, 0, 1};
    tbl[13] = '{0, N, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,                 0, 0, 0,               0, 0, N, 0, 0, 0, 1};
    tbl[14] = '{1, A, 0, 0, 1, 0, 0,            0, 0, 0, 0, 0,                 0, 0, 0,               0, 0, N, 0, 0, 0, 1};
    tbl[15] = '{0, N, 0, 0, 0, 0, 0,            1, 0, 1, 0, 32'hFFFFFFFF,      1, 0, 32'hFFFFFFFF,    1, 1, A, 1, 0, 0, 1};
    tbl[16] = '{1, L, 0, 0, 3, 0, 0,            0, 0, 0, 0, 0,                 0, 0, 0,               0, 1, A, 1, 0, 0, 1};
    tbl[17] = '{1, A, 3, 0, 4, 0, 0,            1, 0, 0, 0, 0,                 0, 0, 0,               1, 1, L, 3, 0, 0, 1};
    tbl[18] = '{1, A, 3, 0, 4, 0, 0,            0, 0, 0, 0, 0,                 0, 0, 0,               1, 1, L, 3, 0, 0, 1};
    tbl[19] = '{0, N, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,                 0, 0, 0,               0, 0, N, 0, 0, 0, 2};

    // Reset state
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset ex_pc", ex_pc, 32'd0);
    chk("reset ex_opcode", 32'(ex_opcode), 32'(N));
    chk("reset ex_funct3", 32'(ex_funct3), 32'd0);
    chk("reset ex_funct7", 32'(ex_funct7), 32'd0);
    chk("reset ex_imm", ex_imm, 32'd0);
`ifdef ID_EX_PERF_EN
    chk("reset stall_cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1;

    // Directed table: forwarding, load-use, stall hold, flush priority, x0 guard
    for (int i = 0; i < 20; i++) begin
      id_valid = tbl[i].v; id_opcode = tbl[i].opc;
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; id_rd = tbl[i].rd;
      id_data1 = tbl[i].d1; id_data2 = tbl[i].d2;
      id_pc = 32'h100 + 32'(i * 4); id_imm = 32'(i);
      stall_in = tbl[i].stall; flush = tbl[i].fl;
      mem_reg_we = tbl[i].mwe; mem_rd = tbl[i].mrd; mem_fwd_data = tbl[i].mdata;
      wb_reg_we = tbl[i].wwe; wb_rd = tbl[i].wrd; wb_data = tbl[i].wdata;
      #3;
      chk($sformatf("step%0d id_stall", i), 32'(id_stall), 32'(tbl[i].e_stall));
      chk($sformatf("step%0d ex_valid", i), 32'(ex_valid), 32'(tbl[i].e_valid));
      chk($sformatf("step%0d ex_opcode", i), 32'(ex_opcode), 32'(tbl[i].e_opc));
      chk($sformatf("step%0d ex_rd", i), 32'(ex_rd), 32'(tbl[i].e_rd));
      chk($sformatf("step%0d ex_data1", i), ex_data1, tbl[i].e_d1);
      chk($sformatf("step%0d ex_data2", i), ex_data2, tbl[i].e_d2);
`ifdef ID_EX_PERF_EN
      chk($sformatf("step%0d stall_cnt", i), stall_cnt, tbl[i].e_cnt);
`endif
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-operation, away from any clock edge
    idle_inputs();
    id_valid = 1; id_opcode = A; id_rd = 5'd12; id_pc = 32'h444; id_imm = 32'h55;
    @(posedge clk);
    #2;
    chk("pre-reset ex_valid", 32'(ex_valid), 32'd1);
    chk("pre-reset ex_pc", ex_pc, 32'h444);
    rst_n = 0;
    #1;
    chk("async reset ex_valid", 32'(ex_valid), 32'd0);
    chk("async reset ex_opcode", 32'(ex_opcode), 32'(N));
    chk("async reset ex_rd", 32'(ex_rd), 32'd0);
    chk("async reset ex_pc", ex_pc, 32'd0);
    chk("async reset ex_imm", ex_imm, 32'd0);
`ifdef ID_EX_PERF_EN
    chk("async reset stall_cnt", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();

    // Randomized run against the behavioural model
    for (int c = 0; c < 600; c++) begin
      logic hazard, exp_stall;
      logic [31:0] e1, e2;
      id_valid = ($urandom_range(0, 9) < 8);
      id_pc = $urandom; id_opcode = opc_pool[$urandom_range(0, 3)];
      id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_data1 = $urandom; id_data2 = $urandom; id_imm = $urandom;
      stall_in = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 10);
      mem_reg_we = $urandom_range(0, 1); mem_rd = 5'($urandom_range(0, 3));
      mem_fwd_data = $urandom;
      wb_reg_we = $urandom_range(0, 1); wb_rd = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      #3;
      hazard = m_valid && m_opc == OPC_LOAD && m_rd != 0 && id_valid &&
               (id_rs1 == m_rd || id_rs2 == m_rd);
      exp_stall = stall_in || (!flush && hazard);
      e1 = fwd(m_rs1, m_d1);
      e2 = fwd(m_rs2, m_d2);
      chk($sformatf("rnd%0d id_stall", c), 32'(id_stall), 32'(exp_stall));
      chk($sformatf("rnd%0d ex_valid", c), 32'(ex_valid), 32'(m_valid));
      chk($sformatf("rnd%0d ex_opcode", c), 32'(ex_opcode), 32'(m_opc));
      chk($sformatf("rnd%0d ex_funct3", c), 32'(ex_funct3), 32'(m_f3));
      chk($sformatf("rnd%0d ex_funct7", c), 32'(ex_funct7), 32'(m_f7));
      chk($sformatf("rnd%0d ex_rd", c), 32'(ex_rd), 32'(m_rd));
      chk($sformatf("rnd%0d ex_imm", c), ex_imm, m_imm);
      chk($sformatf("rnd%0d ex_data1", c), ex_data1, e1);
      chk($sformatf("rnd%0d ex_data2", c), ex_data2, e2);
      if (m_valid) chk($sformatf("rnd%0d ex_pc", c), ex_pc, m_pc);
`ifdef ID_EX_PERF_EN
      chk($sformatf("rnd%0d stall_cnt", c), stall_cnt, m_cnt);
`endif
      if (stall_in) begin
        m_d1 = e1; m_d2 = e2;
      end else if (flush || hazard) begin
        if (!flush) m_cnt = m_cnt + 1;
        m_valid = 0; m_opc = N; m_f3 = 0; m_f7 = 0; m_rd = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_d1 = 0; m_d2 = 0;
      end else begin
        m_valid = id_valid; m_pc = id_pc; m_opc = id_opcode; m_f3 = id_funct3;
        m_f7 = id_funct7; m_rd = id_rd; m_imm = id_imm; m_rs1 = id_rs1;
        m_rs2 = id_rs2; m_d1 = id_data1; m_d2 = id_data2;
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the RV32I 5-stage core, directly upstream of ex_ctrl.
- Captures decoded fields, operands, pc and imm from ID, and resolves RAW hazards on data1/data2 by forwarding from MEM and WB.
- Detects load-use hazards and inserts one bubble.
- Honours downstream stall and branch/jump flush.

Parameters:
NOP_OPCODE, 7'b0010011, opcode driven while the register holds a bubble (ADDI x0,x0,0)
XLEN, 32, datapath width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  32  pc of ID instruction
id_opcode  in  7  opcode
id_funct3  in  3  funct3
id_funct7  in  7  funct7
id_rs1  in  5  source register 1
id_rs2  in  5  source register 2
id_rd  in  5  destination register
id_data1  in  32  register file read, rs1
id_data2  in  32  register file read, rs2
id_imm  in  32  immediate
stall_in  in  1  downstream (MEM) hold request
flush  in  1  taken branch/jump from EX
mem_reg_we  in  1  MEM instruction writes rd
mem_rd  in  5  MEM destination
mem_fwd_data  in  32  MEM result, ALU result or CSR old value
wb_reg_we  in  1  WB instruction writes rd
wb_rd  in  5  WB destination
wb_data  in  32  WB write data
ex_valid  out  1  EX holds a real instruction
ex_pc  out  32  pc to ex_ctrl
ex_opcode  out  7  opcode to ex_ctrl
ex_funct3  out  3  funct3 to ex_ctrl
ex_funct7  out  7  funct7 to ex_ctrl
ex_rd  out  5  destination
ex_imm  out  32  imm to ex_ctrl
ex_data1  out  32  forwarded rs1 value
ex_data2  out  32  forwarded rs2 value
id_stall  out  1  freeze IF/ID this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - ex_valid=0, ex_pc=0, ex_opcode=NOP_OPCODE.
  - funct3, funct7, rd, imm, stored rs1/rs2 and stored data all 0.
  - Applies immediately, mid-operation included.
- Per-cycle priority on rising clk: stall_in > flush > load-use > normal.
  - stall_in=1:
    - All fields hold.
    - Stored data1/data2 reload with the current forwarded ex_data1/ex_data2, so a producer retiring from WB during the hold is not lost.
    - id_stall=1.
  - flush=1 (stall_in=0):
    - Load a bubble: ex_valid=0, opcode=NOP_OPCODE, rd=0, funct3/funct7/imm=0.
    - id_stall=0; ID discards its own instruction.
  - load-use (stall_in=0, flush=0):
    - Hazard condition: ex_valid and ex_opcode==LOAD (0000011) and ex_rd!=0 and id_valid and (id_rs1==ex_rd or id_rs2==ex_rd).
    - Load a bubble; id_stall=1 for exactly this cycle.
    - Next cycle the load is in MEM and the dependent operand is forwarded.
    - Comparison is conservative: both rs fields are compared even when the opcode does not use them.
  - normal: capture all id_* fields; ex_valid=id_valid.
- Otherwise id_stall=0.
- Forwarding is combinational, applied per operand to the stored rs and data:
  - If mem_reg_we and mem_rd!=0 and mem_rd==rs: select mem_fwd_data.
  - Else if wb_reg_we and wb_rd!=0 and wb_rd==rs: select wb_data.
  - Else select stored data.
  - MEM has priority over WB. x0 is never forwarded; ex_data for rs=x0 is the stored value, which is 0.
- Bubble fields drive ex_ctrl to the ADD path with zero operands, so a bubble has no architectural effect.
- Latency: 1 cycle ID to EX. No combinational path from id_* to ex_*.

Optional Feature:
ID_EX_PERF_EN
- Defined: adds output port stall_cnt[31:0], reset 0.
- Increments by 1 on every clock edge where a load-use bubble is inserted.
- Wraps at 2^32.
- Not counted when stall_in or flush wins priority.
- Undefined: port and counter absent. No other behaviour changes.

Decomposition:
- Opcode constants (LOAD, NOP encoding, and the other RV32I opcodes) go in a shared constants include alongside the alu_op and branch_alu_op constants, reused by ex_ctrl.
- One sub-module, fwd_mux: purely combinational, one operand, instantiated twice.

Test Plan:
- Reset: release rst_n while stall_in=0 and id_valid=0. Outputs stay at reset values, ex_opcode=7'b0010011.
- EX/MEM forward:
  - ADDI x5 in MEM, mem_fwd_data=0x00000010, mem_reg_we=1, mem_rd=5.
  - EX holds ADD with rs1=5 and stored data 0x0.
  - Expect ex_data1=0x10.
  - Adding a concurrent WB write to x5=0x20 must still give 0x10.
- Load-use:
  - EX: LW rd=7, ex_valid=1. ID: ADD with rs2=7.
  - Expect id_stall=1 for one cycle and ex_valid=0 next cycle.
  - The following cycle, with mem_fwd_data=0xDEADBEEF, expect ex_data2=0xDEADBEEF.
  - With ID_EX_PERF_EN defined, expect stall_cnt=1.
- Flush vs load-use: flush=1 while a load-use hazard is present. Expect a bubble, id_stall=0, and stall_cnt unchanged.
- Stall hold:
  - stall_in=1 for 3 cycles. All ex_* fields stay constant except data.
  - A WB write to the stored rs1 during the hold is captured: ex_data1 equals that wb_data after WB moves on.
- x0 guard: mem_rd=0, mem_reg_we=1, mem_fwd_data=0xFFFFFFFF, rs1=0. Expect ex_data1=0.
